// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Data-memory responder for the single-cycle RISC-V core. Serves one load or
// store at a time with a programmable wait latency, supports byte / halfword /
// word accesses, sign- or zero-extends loads and flags misaligned or illegal
// accesses.
//
// Parameters:
//   DEPTH_WORDS   number of 32-bit words (power of two, >= 2)
//   READ_LATENCY  cycles from the accepting edge to the edge raising ready (>= 1)
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   req            access request, sampled only while idle
//   we             1 = store, 0 = load
//   size           00 byte, 01 halfword, 10 word, 11 illegal
//   load_unsigned  1 = zero-extend loads, 0 = sign-extend
//   addr           byte address (upper bits beyond the array wrap)
//   wdata          right-aligned store data
//   rdata          load result, valid while ready = 1, otherwise 0
//   ready          one-cycle completion pulse
//   err            high with ready for a misaligned or illegal access
//   busy           high whenever an access is in progress
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH_WORDS  = 1024,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic          we_reg;
  logic [1:0]    size_reg;
  logic          lu_reg;
  logic [AW+1:0] addr_reg;
  logic [31:0]   wdata_reg;
  logic [31:0]   rdata_reg;
  logic          ready_reg;
  logic          err_reg;
  logic          busy_reg;

  // Address bits above the array are deliberately ignored (addresses wrap).
  logic addr_unused;
  assign addr_unused = ^addr[31:AW+2];

  // ---------------------------------------------------------------------------
  // Access classification on the latched request
  // ---------------------------------------------------------------------------
  logic err_cond;
  always_comb begin
    err_cond = 1'b0;
    case (size_reg)
      2'b01:   err_cond = addr_reg[0];
      2'b10:   err_cond = (addr_reg[1:0] != 2'b00);
      2'b11:   err_cond = 1'b1;
      default: err_cond = 1'b0;
    endcase
  end

  logic last_wait;
  assign last_wait = (state_reg == WAIT) && (cnt_reg == '0);

  // ---------------------------------------------------------------------------
  // Store lane steering: replicate the right-aligned data across lanes and
  // enable only the addressed ones.
  // ---------------------------------------------------------------------------
  logic [3:0]  wr_be;
  logic [31:0] wr_lanes;
  logic        wr_en;

  always_comb begin
    wr_be    = 4'b0000;
    wr_lanes = wdata_reg;
    case (size_reg)
      2'b00: begin
        wr_be    = 4'b0001 << addr_reg[1:0];
        wr_lanes = {4{wdata_reg[7:0]}};
      end
      2'b01: begin
        wr_be    = addr_reg[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{wdata_reg[15:0]}};
      end
      2'b10: begin
        wr_be    = 4'b1111;
        wr_lanes = wdata_reg;
      end
      default: begin
        wr_be    = 4'b0000;
        wr_lanes = wdata_reg;
      end
    endcase
  end

  // The write lands on the WAIT->RESP edge; a reset on that edge cancels it.
  assign wr_en = !rst && last_wait && we_reg && !err_cond;

  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  assign wr_idx = addr_reg[AW+1:2];
  assign rd_idx = addr[AW+1:2];

  // ---------------------------------------------------------------------------
  // Storage: one byte-wide RAM per lane with a registered read port.
  // The read is taken from the live address while idle, so on the accepting
  // edge the lane registers capture the addressed word. Nothing else can write
  // the array while the access waits, so the captured word is still current
  // when the response is formed.
  // ---------------------------------------------------------------------------
  logic [31:0] word_q;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH_WORDS];
      logic [7:0] lane_q;

      always_ff @(posedge clk) begin
        if (wr_en && wr_be[gi]) begin
          lane_mem[wr_idx] <= wr_lanes[8*gi +: 8];
        end
        if (state_reg == IDLE) begin
          lane_q <= lane_mem[rd_idx];
        end
      end

      assign word_q[8*gi +: 8] = lane_q;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Load extraction and extension
  // ---------------------------------------------------------------------------
  logic [31:0] load_val;
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  always_comb begin
    load_byte = word_q[7:0];
    case (addr_reg[1:0])
      2'b00:   load_byte = word_q[7:0];
      2'b01:   load_byte = word_q[15:8];
      2'b10:   load_byte = word_q[23:16];
      default: load_byte = word_q[31:24];
    endcase

    load_half = addr_reg[1] ? word_q[31:16] : word_q[15:0];

    load_val = word_q;
    case (size_reg)
      2'b00:   load_val = {{24{load_byte[7] & ~lu_reg}}, load_byte};
      2'b01:   load_val = {{16{load_half[15] & ~lu_reg}}, load_half};
      default: load_val = word_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      we_reg    <= 1'b0;
      size_reg  <= 2'b00;
      lu_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      ready_reg <= 1'b0;
      err_reg   <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          ready_reg <= 1'b0;
          err_reg   <= 1'b0;
          rdata_reg <= '0;
          if (req) begin
            we_reg    <= we;
            size_reg  <= size;
            lu_reg    <= load_unsigned;
            addr_reg  <= addr[AW+1:0];
            wdata_reg <= wdata;
            cnt_reg   <= CW'(READ_LATENCY - 1);
            busy_reg  <= 1'b1;
            state_reg <= WAIT;
          end
        end

        WAIT: begin
          if (cnt_reg == '0) begin
            state_reg <= RESP;
            ready_reg <= 1'b1;
            err_reg   <= err_cond;
            // Stores and faulting accesses answer with zero data.
            rdata_reg <= (!we_reg && !err_cond) ? load_val : 32'd0;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end

        RESP: begin
          state_reg <= IDLE;
          ready_reg <= 1'b0;
          err_reg   <= 1'b0;
          rdata_reg <= '0;
          busy_reg  <= 1'b0;
        end

        default: begin
          state_reg <= IDLE;
          ready_reg <= 1'b0;
          err_reg   <= 1'b0;
          rdata_reg <= '0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign rdata = rdata_reg;
  assign ready = ready_reg;
  assign err   = err_reg;
  assign busy  = busy_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// Testbench for dmem_responder.
// A byte-addressed memory model plus a "pending access with due cycle" model
// predicts ready / err / busy / rdata on every cycle; directed transactions
// additionally pin hand-computed literal results.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int RL = 2;
  localparam int DW = 1024;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        load_unsigned;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  dmem_responder #(
    .DEPTH_WORDS (DW),
    .READ_LATENCY(RL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .we           (we),
    .size         (size),
    .load_unsigned(load_unsigned),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .ready        (ready),
    .err          (err),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic [7:0] mb [0:4095];   // byte memory covering the 1024-word address wrap

  function automatic bit m_bad(input logic [1:0] s, input logic [31:0] a);
    return (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] s, input logic lu, input logic [31:0] a);
    int          n;
    logic [31:0] v;
    logic [11:0] b;
    n = 1 << s;
    v = 32'd0;
    for (int k = 0; k < n; k++) begin
      b = a[11:0] + 12'(k);
      v = v | ({24'd0, mb[b]} << (8 * k));
    end
    if (!lu && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic m_store(input logic [1:0] s, input logic [31:0] a, input logic [31:0] wd);
    int          n;
    logic [11:0] b;
    logic [31:0] sh;
    n = 1 << s;
    for (int k = 0; k < n; k++) begin
      b      = a[11:0] + 12'(k);
      sh     = wd >> (8 * k);
      mb[b]  = sh[7:0];
    end
  endtask

  int          cyc = 0;
  bit          m_pend = 0;
  bit          m_resp = 0;
  int          m_due = 0;
  logic        m_we;
  logic [1:0]  m_size;
  logic        m_lu;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        exp_ready = 1'b0;
  logic        exp_err = 1'b0;
  logic        exp_busy = 1'b0;
  logic [31:0] exp_rdata = 32'd0;
  logic        prev_ready = 1'b0;

  // One compare process: advance the model on each rising edge using the
  // inputs the DUT sampled, then check all outputs just after the edge.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_pend = 0; m_resp = 0;
      exp_ready = 0; exp_err = 0; exp_busy = 0; exp_rdata = 0;
    end else if (m_resp) begin
      m_resp = 0;
      exp_ready = 0; exp_err = 0; exp_busy = 0; exp_rdata = 0;
    end else if (m_pend && cyc == m_due) begin
      m_pend = 0; m_resp = 1;
      exp_ready = 1; exp_busy = 1;
      exp_err   = m_bad(m_size, m_addr);
      exp_rdata = 32'd0;
      if (!exp_err) begin
        if (m_we) m_store(m_size, m_addr, m_wdata);
        else      exp_rdata = m_load(m_size, m_lu, m_addr);
      end
    end else if (m_pend) begin
      exp_ready = 0; exp_err = 0; exp_busy = 1; exp_rdata = 0;
    end else if (req) begin
      m_pend = 1; m_due = cyc + RL;
      m_we = we; m_size = size; m_lu = load_unsigned; m_addr = addr; m_wdata = wdata;
      exp_ready = 0; exp_err = 0; exp_busy = 1; exp_rdata = 0;
    end else begin
      exp_ready = 0; exp_err = 0; exp_busy = 0; exp_rdata = 0;
    end
    #1;
    check("ready", {31'd0, ready}, {31'd0, exp_ready});
    check("err",   {31'd0, err},   {31'd0, exp_err});
    check("busy",  {31'd0, busy},  {31'd0, exp_busy});
    check("rdata", rdata, exp_rdata);
    check("ready_consecutive", {31'd0, ready & prev_ready}, 32'd0);
    prev_ready = ready;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  int n_txn = 0;

  task automatic access(input logic w, input logic [1:0] s, input logic lu,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic e, output int lat);
    bit got;
    @(negedge clk);
    req = 1'b1; we = w; size = s; load_unsigned = lu; addr = a; wdata = wd;
    got = 0; lat = 0; rd = 32'd0; e = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (ready) begin
        got = 1; rd = rdata; e = err;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL ready_timeout: no ready within 20 cycles, expected one (addr=%h)", a);
    end
    @(negedge clk);
    req = 1'b0;
    we = 1'($urandom); size = 2'($urandom); addr = $urandom; wdata = $urandom;
    n_txn++;
    $display("txn %0d: we=%0d size=%0d lu=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
             n_txn, w, s, lu, a, wd, rd, e, lat - 1);
  endtask

  task automatic expect_acc(input string name, input logic w, input logic [1:0] s, input logic lu,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] exp_rd, input logic exp_e);
    logic [31:0] rd;
    logic        e;
    int          lat;
    access(w, s, lu, a, wd, rd, e, lat);
    check({name, "_rdata"}, rd, exp_rd);
    check({name, "_err"}, {31'd0, e}, {31'd0, exp_e});
    // lat counts the accepting edge too.
    check({name, "_latency"}, 32'(lat - 1), 32'd2);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat;
    logic [31:0] r;
    bit          ready_seen;

    rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; load_unsigned = 1'b0;
    addr = 32'd0; wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_busy",  {31'd0, busy},  32'd0);
    check("reset_err",   {31'd0, err},   32'd0);
    check("reset_rdata", rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Fill the test window so every later load has defined contents.
    for (int i = 0; i < 64; i++) access(1'b1, 2'd2, 1'b0, 32'(4 * i), $urandom, rd, e, lat);

    // Word store / load.
    expect_acc("sw_10", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0);
    expect_acc("lw_10", 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);

    // Byte / halfword extension.
    expect_acc("sw_20",  1'b1, 2'd2, 1'b0, 32'h20, 32'h80FF7F01, 32'd0, 1'b0);
    expect_acc("lb_23",  1'b0, 2'd0, 1'b0, 32'h23, 32'd0, 32'hFFFFFF80, 1'b0);
    expect_acc("lbu_23", 1'b0, 2'd0, 1'b1, 32'h23, 32'd0, 32'h00000080, 1'b0);
    expect_acc("lh_20",  1'b0, 2'd1, 1'b0, 32'h20, 32'd0, 32'h00007F01, 1'b0);
    expect_acc("lh_22",  1'b0, 2'd1, 1'b0, 32'h22, 32'd0, 32'hFFFF80FF, 1'b0);
    expect_acc("lhu_22", 1'b0, 2'd1, 1'b1, 32'h22, 32'd0, 32'h000080FF, 1'b0);

    // Partial store lanes.
    expect_acc("sw_30", 1'b1, 2'd2, 1'b0, 32'h30, 32'h11223344, 32'd0, 1'b0);
    expect_acc("sb_31", 1'b1, 2'd0, 1'b0, 32'h31, 32'h000000AA, 32'd0, 1'b0);
    expect_acc("sh_32", 1'b1, 2'd1, 1'b0, 32'h32, 32'h0000BEEF, 32'd0, 1'b0);
    expect_acc("lw_30", 1'b0, 2'd2, 1'b0, 32'h30, 32'd0, 32'hBEEFAA44, 1'b0);

    // Misaligned / illegal.
    expect_acc("lw_32_mis", 1'b0, 2'd2, 1'b0, 32'h32, 32'd0, 32'd0, 1'b1);
    expect_acc("sh_31_mis", 1'b1, 2'd1, 1'b0, 32'h31, 32'h00005555, 32'd0, 1'b1);
    expect_acc("size11",    1'b1, 2'd3, 1'b0, 32'h30, 32'hFFFFFFFF, 32'd0, 1'b1);
    expect_acc("lw_30_again", 1'b0, 2'd2, 1'b0, 32'h30, 32'd0, 32'hBEEFAA44, 1'b0);

    // Address wrap: bits above the array are ignored.
    expect_acc("lw_30_wrap", 1'b0, 2'd2, 1'b0, 32'hABC0_1030, 32'd0, 32'hBEEFAA44, 1'b0);

    // Reset in the middle of a store.
    expect_acc("sw_40", 1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFEF00D, 32'd0, 1'b0);
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'd2; load_unsigned = 1'b0; addr = 32'h40; wdata = 32'h12345678;
    @(posedge clk);            // accepting edge
    @(negedge clk);
    req = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_ready", {31'd0, ready}, 32'd0);
    check("rst_mid_busy",  {31'd0, busy},  32'd0);
    check("rst_mid_rdata", rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ready_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (ready) ready_seen = 1;
    end
    check("rst_mid_no_ready", {31'd0, ready_seen}, 32'd0);
    expect_acc("lw_40", 1'b0, 2'd2, 1'b0, 32'h40, 32'd0, 32'hCAFEF00D, 1'b0);

    // Back-to-back: req held high with changing fields; the per-cycle model
    // checks acceptance spacing, busy and ready.
    @(negedge clk);
    req = 1'b1;
    for (int i = 0; i < 30; i++) begin
      r = $urandom;
      we = r[0]; size = {1'b0, r[1]} + {1'b0, r[2]}; load_unsigned = r[3];
      addr = {20'd0, 4'd0, r[15:8]};
      wdata = $urandom;
      @(negedge clk);
    end
    req = 1'b0;
    repeat (6) @(negedge clk);

    // Randomized accesses inside the filled window, with address aliases.
    for (int i = 0; i < 200; i++) begin
      r = $urandom;
      access(r[0], r[2:1], r[3], {$urandom_range(0, 32'hFFFFF) & 32'hFFFFF, 4'd0, r[15:8]} , $urandom, rd, e, lat);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
